bomb_projectile: RTL

Launch-responder for the player's bomb controls: on a rising edge of `launch` it captures launch point, aim angle and power, flies a ballistic projectile under gravity each frame, detects terrain or screen-edge termination, then runs a timed blast. On terrain impact it pulses `exploded` for one frame and presents the cratered terrain map on `terrain_out`. The top level latches `terrain_out` as the new terrain while `exploded` is high.

---
 rtl/bomb_pkg.sv | 25 ++
 rtl/terrain_crater.sv | 22 ++
 rtl/bomb_projectile.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/bomb_pkg.sv
// Shared types and constants for the bomb projectile: FSM states, aim tables,
// terrain geometry and screen bounds.
package bomb_pkg;

  typedef enum logic [1:0] {IDLE, FLIGHT, BLAST} state_t;

  localparam int unsigned ColWidth   = 16;
  localparam int unsigned NumCols    = 40;
  localparam int unsigned EntryMax   = 239;
  localparam int unsigned ScreenXMax = 639;
  localparam int unsigned ScreenYMax = 479;

  // Index 0 points left, 4 straight up, 8 right; magnitude 8 == 1 px/frame.
  localparam logic signed [4:0] CosTab [9] =
    '{-5'sd8, -5'sd7, -5'sd6, -5'sd3, 5'sd0, 5'sd3, 5'sd6, 5'sd7, 5'sd8};
  localparam logic signed [4:0] SinTab [9] =
    '{5'sd0, 5'sd3, 5'sd6, 5'sd7, 5'sd8, 5'sd7, 5'sd6, 5'sd3, 5'sd0};

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > 9'(EntryMax)) ? 8'(EntryMax) : s[7:0];
  endfunction

endpackage

// File: rtl/terrain_crater.sv
// Combinational crater stamp: deepens the impact column and its two neighbours,
// clipped to the used columns and saturated at the lowest legal surface.
module terrain_crater
  import bomb_pkg::*;
(
  input  logic [511:0] terrain_data,
  input  logic [5:0]   column,
  input  logic [7:0]   depth,
  output logic [511:0] cratered
);

  always_comb begin
    cratered = terrain_data;
    // Only columns 0..NumCols-1 are touched, so neighbours never wrap to column 63.
    for (int i = 0; i < int'(NumCols); i++) begin
      if ((i + 1 >= int'(column)) && (i <= int'(column) + 1)) begin
        cratered[8*i +: 8] = sat_add(terrain_data[8*i +: 8], depth);
      end
    end
  end

endmodule

// File: rtl/bomb_projectile.sv
// Bomb launch responder: ballistic flight under gravity, terrain/edge termination,
// then a timed blast with a one-frame crater update of the terrain map.
module bomb_projectile
  import bomb_pkg::*;
#(
  parameter int unsigned GRAV         = 2,
  parameter int unsigned GRAV_DIV     = 1,
  parameter int unsigned VY_MAX       = 64,
  parameter int unsigned CRATER_DEPTH = 8,
  parameter int unsigned BLAST_FRAMES = 12,
  parameter int unsigned BOMB_R       = 2,
  parameter int unsigned BLAST_R      = 14
) (
  input  logic         frame_clk,
  input  logic         reset,
  input  logic         launch,
  input  logic [9:0]   launchX,
  input  logic [9:0]   launchY,
  input  logic [3:0]   angle,
  input  logic [2:0]   power,
  input  logic [511:0] terrain_data,
  output logic [9:0]   X,
  output logic [9:0]   Y,
  output logic [9:0]   S,
  output logic         exploded,
  output logic [511:0] terrain_out
);

  localparam int unsigned CntW    = $clog2(BLAST_FRAMES + 1);
  localparam int unsigned RampDen = (BLAST_FRAMES > 1) ? BLAST_FRAMES - 1 : 1;

  state_t             state_q;
  logic signed [13:0] pos_x_q, pos_y_q;
  logic signed [9:0]  vel_x_q, vel_y_q;
  logic [7:0]         grav_cnt_q;
  logic [CntW-1:0]    blast_cnt_q;
  logic               launch_prev_q;

  logic [3:0]         ang;
  logic signed [4:0]  speed;
  logic signed [9:0]  launch_vx, launch_vy;
  logic signed [13:0] next_x, next_y;
  logic signed [10:0] vy_sum;
  logic signed [9:0]  vy_sat;
  logic [5:0]         hit_col;
  logic [8:0]         surface_y;
  logic               launch_edge, off_screen, hit, grav_step, blast_done;
  logic [9:0]         ramp_s;
  logic [511:0]       cratered;

  always_comb begin
    ang       = (angle > 4'd8) ? 4'd8 : angle;
    speed     = $signed({2'b00, power}) + 5'sd1;
    launch_vx = 10'(CosTab[ang]) * 10'(speed);
    launch_vy = -(10'(SinTab[ang]) * 10'(speed));

    next_x = pos_x_q + 14'(vel_x_q);
    next_y = pos_y_q + 14'(vel_y_q);
    // Bit 13 is the sign; [12:3] is the pixel part of a non-negative coordinate.
    off_screen = next_x[13] || (next_x[12:3] > 10'(ScreenXMax)) ||
                 (!next_y[13] && (next_y[12:3] > 10'(ScreenYMax)));
    hit_col    = next_x[12:7];
    surface_y  = {terrain_data[{hit_col, 3'b000} +: 8], 1'b0};
    hit        = !next_y[13] && (next_y[12:3] >= {1'b0, surface_y});

    grav_step = (grav_cnt_q == 8'(GRAV_DIV - 1));
    vy_sum    = 11'(vel_y_q) + $signed(11'(GRAV));
    vy_sat    = (vy_sum > $signed(11'(VY_MAX))) ? 10'(VY_MAX) : vy_sum[9:0];

    launch_edge = launch && !launch_prev_q;
    blast_done  = (blast_cnt_q == CntW'(BLAST_FRAMES - 1));
    ramp_s      = 10'(BOMB_R + ((BLAST_R - BOMB_R) * (32'(blast_cnt_q) + 32'd1)) / RampDen);
  end

  terrain_crater u_crater (
    .terrain_data (terrain_data),
    .column       (hit_col),
    .depth        (8'(CRATER_DEPTH)),
    .cratered     (cratered)
  );

  always_ff @(posedge frame_clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      pos_x_q       <= '0;
      pos_y_q       <= '0;
      vel_x_q       <= '0;
      vel_y_q       <= '0;
      grav_cnt_q    <= '0;
      blast_cnt_q   <= '0;
      launch_prev_q <= 1'b1;  // a launch held through reset must not fire
      X             <= '0;
      Y             <= '0;
      S             <= '0;
      exploded      <= 1'b0;
      terrain_out   <= '0;
    end else begin
      launch_prev_q <= launch;
      exploded      <= 1'b0;
      terrain_out   <= terrain_data;
      unique case (state_q)
        IDLE: begin
          X <= launchX;
          Y <= launchY;
          S <= '0;
          if (launch_edge) begin
            state_q    <= FLIGHT;
            pos_x_q    <= {1'b0, launchX, 3'b000};
            pos_y_q    <= {1'b0, launchY, 3'b000};
            vel_x_q    <= launch_vx;
            vel_y_q    <= launch_vy;
            grav_cnt_q <= '0;
            S          <= 10'(BOMB_R);
          end
        end
        FLIGHT: begin
          if (off_screen) begin
            state_q <= IDLE;
            X       <= launchX;
            Y       <= launchY;
            S       <= '0;
          end else begin
            pos_x_q <= next_x;
            pos_y_q <= next_y;
            X       <= next_x[12:3];
            Y       <= next_y[12:3];
            if (hit) begin
              state_q     <= BLAST;
              blast_cnt_q <= '0;
              exploded    <= 1'b1;
              terrain_out <= cratered;
            end else if (grav_step) begin
              vel_y_q    <= vy_sat;
              grav_cnt_q <= '0;
            end else begin
              grav_cnt_q <= grav_cnt_q + 8'd1;
            end
          end
        end
        BLAST: begin
          if (blast_done) begin
            state_q <= IDLE;
            X       <= launchX;
            Y       <= launchY;
            S       <= '0;
          end else begin
            blast_cnt_q <= blast_cnt_q + 1'b1;
            S           <= ramp_s;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
